usb3_rx_framer: RTL and testbench

Link-layer receive framer sitting directly downstream of the RX descrambler. It consumes the descrambled, SKP-free 32-bit symbol stream and recognises word-aligned framing ordered sets: HPSTART, DPPSTART, DPPEND and DPPABORT. It extracts Header Packets as a single parallel record and streams Data Packet Payload words with an end/abort indication. CRC checking is left to the link/protocol layer that consumes these outputs.

---
 rtl/usb3_rx_framer_pkg.sv | 31 +++
 rtl/usb3_rx_framer_os_detect.sv | 47 ++++
 rtl/usb3_rx_framer.sv | 178 +++++++++++++++++
 tb/tb_usb3_rx_framer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb3_rx_framer_pkg.sv
// Shared USB3 link-layer K-code constants and framing helpers for the RX framer.
// Byte 0 of a word is [31:24], the earliest symbol on the wire.
package usb3_rx_framer_pkg;

    localparam logic [7:0] K_SHP = 8'hFB;  // K27.7
    localparam logic [7:0] K_SDP = 8'h5C;  // K28.2
    localparam logic [7:0] K_END = 8'hFD;  // K29.7
    localparam logic [7:0] K_EDB = 8'h7C;  // K28.3
    localparam logic [7:0] K_EPF = 8'hF7;  // K23.7

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned HP_WORDS = 4;

    function automatic logic is_framing_code(input logic [7:0] b);
        return (b == K_SHP) || (b == K_SDP) || (b == K_END) ||
               (b == K_EDB) || (b == K_EPF);
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] w, input int unsigned idx);
        logic [7:0] b;
        b = '0;
        case (idx)
            0:       b = w[31:24];
            1:       b = w[23:16];
            2:       b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/usb3_rx_framer_os_detect.sv
// Combinational classifier: recognises one word-aligned framing ordered set,
// or flags a word carrying framing K codes that do not form a complete set.
module usb3_rx_os_detect
    import usb3_rx_framer_pkg::*;
(
    input  logic [31:0] data,
    input  logic [3:0]  datak,
    output logic        is_hpstart,
    output logic        is_dppstart,
    output logic        is_dppend,
    output logic        is_dppabort,
    output logic        is_bad_framing
);

    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic       set_shape;
    logic       any_framing;
    logic       any_set;

    always_comb begin
        b0 = word_byte(data, 0);
        b1 = word_byte(data, 1);
        b2 = word_byte(data, 2);
        b3 = word_byte(data, 3);

        set_shape = (&datak) && (b0 == b1) && (b1 == b2) && (b3 == K_EPF);

        is_hpstart  = set_shape && (b0 == K_SHP);
        is_dppstart = set_shape && (b0 == K_SDP);
        is_dppend   = set_shape && (b0 == K_END);
        is_dppabort = set_shape && (b0 == K_EDB);
        any_set     = is_hpstart || is_dppstart || is_dppend || is_dppabort;

        // datak[3] pairs with byte 0, datak[0] with byte 3
        any_framing = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (datak[3 - i] && is_framing_code(word_byte(data, i)))
                any_framing = 1'b1;
        end

        is_bad_framing = any_framing && !any_set;
    end

endmodule

// File: rtl/usb3_rx_framer.sv
// USB3 link-layer RX framer: extracts Header Packets as one record and
// streams DPP payload words with last/abort and framing error pulses.
module usb3_rx_framer
    import usb3_rx_framer_pkg::*;
#(
    parameter int unsigned DPP_MAX_WORDS = 257
) (
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_active,
    output logic        hp_valid,
    output logic [95:0] hp_data,
    output logic [15:0] hp_crc,
    output logic [15:0] hp_lcw,
    output logic        dpp_valid,
    output logic [31:0] dpp_data,
    output logic        dpp_last,
    output logic        dpp_abort,
    output logic        err_frame,
    output logic        err_dpp_overflow,
    output logic        err_dpp_short
);

    localparam int unsigned CNT_W = $clog2(DPP_MAX_WORDS + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HP,
        ST_DPP
    } state_t;

    state_t           state;
    logic [1:0]       hp_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      hold;
    logic             have_hold;

    logic is_hpstart;
    logic is_dppstart;
    logic is_dppend;
    logic is_dppabort;
    logic is_bad_framing;
    logic is_any_set;

    usb3_rx_os_detect u_os_detect (
        .data           (in_data),
        .datak          (in_datak),
        .is_hpstart     (is_hpstart),
        .is_dppstart    (is_dppstart),
        .is_dppend      (is_dppend),
        .is_dppabort    (is_dppabort),
        .is_bad_framing (is_bad_framing)
    );

    assign is_any_set = is_hpstart | is_dppstart | is_dppend | is_dppabort;

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            hp_cnt           <= '0;
            word_cnt         <= '0;
            hold             <= '0;
            have_hold        <= 1'b0;
            hp_valid         <= 1'b0;
            hp_data          <= '0;
            hp_crc           <= '0;
            hp_lcw           <= '0;
            dpp_valid        <= 1'b0;
            dpp_data         <= '0;
            dpp_last         <= 1'b0;
            dpp_abort        <= 1'b0;
            err_frame        <= 1'b0;
            err_dpp_overflow <= 1'b0;
            err_dpp_short    <= 1'b0;
        end else begin
            hp_valid         <= 1'b0;
            dpp_valid        <= 1'b0;
            dpp_last         <= 1'b0;
            dpp_abort        <= 1'b0;
            err_frame        <= 1'b0;
            err_dpp_overflow <= 1'b0;
            err_dpp_short    <= 1'b0;

            if (!enable) begin
                state     <= ST_IDLE;
                hp_cnt    <= '0;
                word_cnt  <= '0;
                have_hold <= 1'b0;
            end else if (in_active) begin
                if (state == ST_DPP) begin
                    if (is_bad_framing) begin
                        err_frame <= 1'b1;
                        have_hold <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (is_hpstart) begin
                        err_frame <= 1'b1;
                        have_hold <= 1'b0;
                        hp_cnt    <= '0;
                        state     <= ST_HP;
                    end else if (is_dppstart) begin
                        err_frame <= 1'b1;
                        have_hold <= 1'b0;
                        word_cnt  <= '0;
                        state     <= ST_DPP;
                    end else if (is_dppend) begin
                        if (have_hold) begin
                            dpp_valid <= 1'b1;
                            dpp_data  <= hold;
                            dpp_last  <= 1'b1;
                        end else begin
                            err_dpp_short <= 1'b1;
                        end
                        have_hold <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (is_dppabort) begin
                        dpp_abort <= 1'b1;
                        have_hold <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (word_cnt == CNT_W'(DPP_MAX_WORDS)) begin
                        // This word would be number DPP_MAX_WORDS+1: drop the packet
                        err_dpp_overflow <= 1'b1;
                        have_hold        <= 1'b0;
                        state            <= ST_IDLE;
                    end else begin
                        if (have_hold) begin
                            dpp_valid <= 1'b1;
                            dpp_data  <= hold;
                        end
                        hold      <= in_data;
                        have_hold <= 1'b1;
                        word_cnt  <= word_cnt + 1'b1;
                    end
                end else begin
                    // IDLE and HP share the restart path; an ordered set inside HP
                    // is additionally a framing error
                    if (state == ST_HP && is_any_set)
                        err_frame <= 1'b1;

                    if (is_bad_framing) begin
                        err_frame <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (is_hpstart) begin
                        hp_cnt <= '0;
                        state  <= ST_HP;
                    end else if (is_dppstart) begin
                        have_hold <= 1'b0;
                        word_cnt  <= '0;
                        state     <= ST_DPP;
                    end else if (is_dppend || is_dppabort) begin
                        err_frame <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (state == ST_HP) begin
                        case (hp_cnt)
                            2'd0: hp_data[95:64] <= in_data;
                            2'd1: hp_data[63:32] <= in_data;
                            2'd2: hp_data[31:0]  <= in_data;
                            default: begin
                                hp_crc <= in_data[31:16];
                                hp_lcw <= in_data[15:0];
                            end
                        endcase
                        if (hp_cnt == 2'(HP_WORDS - 1)) begin
                            hp_valid <= 1'b1;
                            hp_cnt   <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            hp_cnt <= hp_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb3_rx_framer.sv
// Directed bench for usb3_rx_framer: one task per scenario, inline checks
// against hand-computed expectations.
module tb_usb3_rx_framer;

    logic        local_clk;
    logic        reset_n;
    logic        enable;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        in_active;
    logic        hp_valid;
    logic [95:0] hp_data;
    logic [15:0] hp_crc;
    logic [15:0] hp_lcw;
    logic        dpp_valid;
    logic [31:0] dpp_data;
    logic        dpp_last;
    logic        dpp_abort;
    logic        err_frame;
    logic        err_dpp_overflow;
    logic        err_dpp_short;

    localparam logic [31:0] W_HPSTART = 32'hFBFBFBF7;
    localparam logic [31:0] W_DPPSTART = 32'h5C5C5CF7;
    localparam logic [31:0] W_DPPEND = 32'hFDFDFDF7;
    localparam logic [31:0] W_DPPABORT = 32'h7C7C7CF7;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_s = 0;

    logic [32:0]  dpp_q[$];
    int           dpp_cyc[$];
    logic [127:0] hp_q[$];
    int           hp_cyc[$];
    int n_abort, n_frame, n_ovf, n_short;

    usb3_rx_framer #(.DPP_MAX_WORDS(257)) dut (
        .local_clk        (local_clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .in_data          (in_data),
        .in_datak         (in_datak),
        .in_active        (in_active),
        .hp_valid         (hp_valid),
        .hp_data          (hp_data),
        .hp_crc           (hp_crc),
        .hp_lcw           (hp_lcw),
        .dpp_valid        (dpp_valid),
        .dpp_data         (dpp_data),
        .dpp_last         (dpp_last),
        .dpp_abort        (dpp_abort),
        .err_frame        (err_frame),
        .err_dpp_overflow (err_dpp_overflow),
        .err_dpp_short    (err_dpp_short)
    );

    initial local_clk = 1'b0;
    always #4 local_clk = ~local_clk;

    always @(posedge local_clk) begin
        cyc = cyc + 1;
        #1;
        if (dpp_valid) begin
            dpp_q.push_back({dpp_last, dpp_data});
            dpp_cyc.push_back(cyc);
        end
        if (hp_valid) begin
            hp_q.push_back({hp_data, hp_crc, hp_lcw});
            hp_cyc.push_back(cyc);
        end
        if (dpp_abort)        n_abort++;
        if (err_frame)        n_frame++;
        if (err_dpp_overflow) n_ovf++;
        if (err_dpp_short)    n_short++;
    end

    task automatic clear_log();
        dpp_q.delete();
        dpp_cyc.delete();
        hp_q.delete();
        hp_cyc.delete();
        n_abort = 0; n_frame = 0; n_ovf = 0; n_short = 0;
    endtask

    // One active word, sampled at edge index last_s
    task automatic put(input logic [31:0] d, input logic [3:0] k);
        @(negedge local_clk);
        in_data   = d;
        in_datak  = k;
        in_active = 1'b1;
        last_s    = cyc + 1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge local_clk);
            in_active = 1'b0;
            in_data   = 32'h0;
            in_datak  = 4'h0;
        end
    endtask

    task automatic check_counts(input string name, input int ab, input int fr,
                                input int ov, input int sh);
        vectors++;
        if ({n_abort, n_frame, n_ovf, n_short} !== {ab, fr, ov, sh}) begin
            miscompares++;
            $display("FAIL %s pulses abort/frame/ovf/short got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     name, n_abort, n_frame, n_ovf, n_short, ab, fr, ov, sh);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        vectors++;
        if ({hp_valid, dpp_valid, dpp_last, dpp_abort, err_frame, err_dpp_overflow, err_dpp_short} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 0", {hp_valid, dpp_valid, dpp_last, dpp_abort,
                     err_frame, err_dpp_overflow, err_dpp_short});
        end
        vectors++;
        if ({hp_data, hp_crc, hp_lcw, dpp_data} !== 160'b0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0", {hp_data, hp_crc, hp_lcw, dpp_data});
        end
        @(negedge local_clk);
        reset_n = 1'b1;
        gap(2);
    endtask

    task automatic test_hp();
        int ls;
        clear_log();
        put(W_HPSTART, 4'hF);
        put(32'h11111111, 4'h0);
        put(32'h22222222, 4'h0);
        put(32'h33333333, 4'h0);
        put(32'hAAAABBBB, 4'h0);
        ls = last_s;
        gap(3);
        vectors++;
        if (hp_q.size() !== 1) begin
            miscompares++;
            $display("FAIL hp_count got %0d want 1", hp_q.size());
        end else begin
            vectors++;
            if (hp_q[0] !== 128'h111111112222222233333333AAAABBBB) begin
                miscompares++;
                $display("FAIL hp_record got %h want 111111112222222233333333AAAABBBB", hp_q[0]);
            end
            vectors++;
            if (hp_cyc[0] !== ls) begin
                miscompares++;
                $display("FAIL hp_timing got cycle %0d want %0d", hp_cyc[0], ls);
            end
        end
        check_counts("hp_errs", 0, 0, 0, 0);
    endtask

    task automatic run_dpp(input string name, input bit with_gap);
        int s;
        int exp_off[3];
        logic [32:0] exp_w[3];
        exp_w[0] = {1'b0, 32'hDEADBEEF};
        exp_w[1] = {1'b0, 32'h01234567};
        exp_w[2] = {1'b1, 32'h89ABCDEF};
        exp_off[0] = with_gap ? 3 : 2;
        exp_off[1] = with_gap ? 4 : 3;
        exp_off[2] = with_gap ? 5 : 4;
        clear_log();
        put(W_DPPSTART, 4'hF);
        s = last_s;
        put(32'hDEADBEEF, 4'h0);
        if (with_gap) gap(1);
        put(32'h01234567, 4'h0);
        put(32'h89ABCDEF, 4'h0);
        put(W_DPPEND, 4'hF);
        gap(3);
        vectors++;
        if (dpp_q.size() !== 3) begin
            miscompares++;
            $display("FAIL %s_count got %0d want 3", name, dpp_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (dpp_q[i] !== exp_w[i] || (dpp_cyc[i] - s) !== exp_off[i]) begin
                    miscompares++;
                    $display("FAIL %s_word%0d got last/data %h at +%0d want %h at +%0d",
                             name, i, dpp_q[i], dpp_cyc[i] - s, exp_w[i], exp_off[i]);
                end
            end
        end
        check_counts({name, "_errs"}, 0, 0, 0, 0);
    endtask

    task automatic test_dpp();
        run_dpp("dpp", 1'b0);
    endtask

    task automatic test_dpp_gap();
        run_dpp("dpp_gap", 1'b1);
    endtask

    task automatic test_abort_short();
        clear_log();
        put(W_DPPSTART, 4'hF);
        put(32'hCAFEF00D, 4'h0);
        put(W_DPPABORT, 4'hF);
        gap(3);
        vectors++;
        if (dpp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL abort_nodata got %0d words want 0", dpp_q.size());
        end
        check_counts("abort_pulses", 1, 0, 0, 0);
        clear_log();
        put(W_DPPSTART, 4'hF);
        put(W_DPPEND, 4'hF);
        gap(3);
        vectors++;
        if (dpp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL short_nodata got %0d words want 0", dpp_q.size());
        end
        check_counts("short_pulses", 0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        int bad_idx;
        clear_log();
        put(W_DPPSTART, 4'hF);
        for (int i = 1; i <= 258; i++) put(32'(i), 4'h0);
        gap(3);
        vectors++;
        if (dpp_q.size() !== 256) begin
            miscompares++;
            $display("FAIL ovf_count got %0d want 256", dpp_q.size());
        end else begin
            bad_idx = -1;
            for (int i = 0; i < 256; i++)
                if (bad_idx < 0 && dpp_q[i] !== {1'b0, 32'(i + 1)}) bad_idx = i;
            vectors++;
            if (bad_idx !== -1) begin
                miscompares++;
                $display("FAIL ovf_data got %h at index %0d want %h", dpp_q[bad_idx], bad_idx,
                         {1'b0, 32'(bad_idx + 1)});
            end
        end
        check_counts("ovf_pulses", 0, 0, 1, 0);
        // back in IDLE: a stray data word is dropped and DPPEND is a framing error
        clear_log();
        put(32'h55555555, 4'h0);
        put(W_DPPEND, 4'hF);
        gap(3);
        vectors++;
        if (dpp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL ovf_idle got %0d words want 0", dpp_q.size());
        end
        check_counts("ovf_idle_pulses", 0, 1, 0, 0);
    endtask

    task automatic test_bad_frame_reset();
        clear_log();
        put(32'hFBFB5CF7, 4'hF);
        gap(2);
        check_counts("bad_set", 0, 1, 0, 0);
        clear_log();
        put(32'h000000F7, 4'h1);
        gap(2);
        check_counts("lone_epf", 0, 1, 0, 0);

        clear_log();
        put(W_HPSTART, 4'hF);
        put(32'h99999999, 4'h0);
        put(32'h88888888, 4'h0);
        @(negedge local_clk);
        in_active = 1'b0;
        #2;
        reset_n = 1'b0;
        #2;
        vectors++;
        if ({hp_valid, dpp_valid, dpp_last, dpp_abort, err_frame, err_dpp_overflow, err_dpp_short,
             hp_data, hp_crc, hp_lcw, dpp_data} !== 167'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs got nonzero output state");
        end
        @(negedge local_clk);
        reset_n = 1'b1;
        clear_log();
        put(W_HPSTART, 4'hF);
        put(32'h01020304, 4'h0);
        put(32'h05060708, 4'h0);
        put(32'h090A0B0C, 4'h0);
        put(32'h1234ABCD, 4'h0);
        gap(3);
        vectors++;
        if (hp_q.size() !== 1 || hp_q[0] !== 128'h0102030405060708090A0B0C1234ABCD) begin
            miscompares++;
            $display("FAIL hp_after_reset got %0d records first %h want 1 of 0102030405060708090A0B0C1234ABCD",
                     hp_q.size(), hp_q.size() > 0 ? hp_q[0] : 128'h0);
        end
        check_counts("hp_after_reset_errs", 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        clear_log();
        put(W_DPPSTART, 4'hF);
        put(32'h0BADC0DE, 4'h0);
        put(W_DPPEND, 4'hF);
        put(W_HPSTART, 4'hF);
        put(32'hA0A0A0A0, 4'h0);
        put(32'hB0B0B0B0, 4'h0);
        put(32'hC0C0C0C0, 4'h0);
        put(32'hD0D0E0E0, 4'h0);
        gap(3);
        vectors++;
        if (dpp_q.size() !== 1 || dpp_q[0] !== {1'b1, 32'h0BADC0DE}) begin
            miscompares++;
            $display("FAIL b2b_dpp got %0d words first %h want 1 of 10badc0de",
                     dpp_q.size(), dpp_q.size() > 0 ? dpp_q[0] : 33'h0);
        end
        vectors++;
        if (hp_q.size() !== 1 || hp_q[0] !== 128'hA0A0A0A0B0B0B0B0C0C0C0C0D0D0E0E0) begin
            miscompares++;
            $display("FAIL b2b_hp got %0d records first %h want 1 of a0a0a0a0b0b0b0b0c0c0c0c0d0d0e0e0",
                     hp_q.size(), hp_q.size() > 0 ? hp_q[0] : 128'h0);
        end
        check_counts("b2b_errs", 0, 0, 0, 0);
    endtask

    task automatic test_enable();
        clear_log();
        put(W_DPPSTART, 4'hF);
        put(32'h77777777, 4'h0);
        @(negedge local_clk);
        enable    = 1'b0;
        in_data   = 32'h66666666;
        in_datak  = 4'h0;
        in_active = 1'b1;
        @(negedge local_clk);
        enable    = 1'b1;
        in_active = 1'b0;
        put(W_DPPEND, 4'hF);
        gap(3);
        vectors++;
        if (dpp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL enable_nodata got %0d words want 0", dpp_q.size());
        end
        check_counts("enable_pulses", 0, 1, 0, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        in_data   = 32'h0;
        in_datak  = 4'h0;
        in_active = 1'b0;
        test_reset();
        test_hp();
        test_dpp();
        test_dpp_gap();
        test_abort_short();
        test_overflow();
        test_bad_frame_reset();
        test_back_to_back();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
